// File: rtl/pipelined_adder_nbit.sv
// rtl/pipelined_adder_nbit.sv - WIDTH-bit ripple-carry adder split into STAGES register slices
// Optional subtract mode (sub_in port) is enabled by defining ADDER_SUB_EN.
module pipelined_adder_nbit #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
`ifdef ADDER_SUB_EN
  input  logic             sub_in,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CHUNK = (STAGES > 0) ? WIDTH / STAGES : 1;

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_adder_nbit: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
  end

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [CHUNK:0]   part;

`ifdef ADDER_SUB_EN
  assign b_eff = sub_in ? ~b_in : b_in;
  assign c_eff = sub_in ? 1'b1 : c_in;
`else
  assign b_eff = b_in;
  assign c_eff = c_in;
`endif

  // Whole pipeline moves as one; a stalled output freezes every slice.
  assign advance  = ~valid_q[STAGES-1] | out_ready;
  assign in_ready = advance;

  function automatic logic [CHUNK:0] chunk_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             c,
                                               input int               k);
    return {1'b0, a[k*CHUNK +: CHUNK]} + {1'b0, b[k*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, c};
  endfunction

  always_comb begin
    valid_d = '0;
    carry_d = '0;
    part    = '0;
    for (int k = 0; k < STAGES; k++) begin
      a_d[k]   = '0;
      b_d[k]   = '0;
      sum_d[k] = '0;
    end

    // Bubbles load zeros so idle-cycle operands never reach the outputs.
    part = chunk_add(a_in, b_eff, c_eff, 0);
    if (in_valid) begin
      valid_d[0]              = 1'b1;
      a_d[0]                  = a_in;
      b_d[0]                  = b_eff;
      sum_d[0][CHUNK-1:0]     = part[CHUNK-1:0];
      carry_d[0]              = part[CHUNK];
    end

    for (int k = 1; k < STAGES; k++) begin
      part = chunk_add(a_q[k-1], b_q[k-1], carry_q[k-1], k);
      if (valid_q[k-1]) begin
        valid_d[k]                = 1'b1;
        a_d[k]                    = a_q[k-1];
        b_d[k]                    = b_q[k-1];
        sum_d[k]                  = sum_q[k-1];
        sum_d[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
        carry_d[k]                = part[CHUNK];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else if (advance) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign c_out     = carry_q[STAGES-1];
  // b_q holds the operand actually added, so subtract overflow falls out of the same rule.
  assign ovf       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &
                     (sum_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// tb/tb_pipelined_adder_nbit.sv - randomized + directed bench for pipelined_adder_nbit
// Three instances (8/2, 16/4, 16/1) share stimulus; a queue scoreboard models plain arithmetic.
module tb_pipelined_adder_nbit;

  typedef struct packed {
    logic [15:0] sum;
    logic        co;
    logic        ovf;
  } res_t;

  typedef struct {
    res_t r;
    int   cyc;
    bit   chk;
  } exp_t;

  localparam int WID [3] = '{8, 16, 16};
  localparam int LAT [3] = '{2, 4, 1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a_s, b_s;
  logic        c_s, sub_s;
  logic        sub_eff;

  logic        rdy [3];
  logic        ov  [3];
  logic [15:0] sm  [3];
  logic        co  [3];
  logic        of  [3];
  logic [7:0]  sum8;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   lat_chk  = 1'b1;
  exp_t q [3][$];
  exp_t mon_e;
  res_t mon_got;

`ifdef ADDER_SUB_EN
  assign sub_eff = sub_s;
`else
  assign sub_eff = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_adder_nbit #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk_in(clk), .rst_n_in(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .a_in(a_s[7:0]), .b_in(b_s[7:0]), .c_in(c_s),
`ifdef ADDER_SUB_EN
    .sub_in(sub_s),
`endif
    .out_valid(ov[0]), .out_ready(out_ready), .sum(sum8), .c_out(co[0]), .ovf(of[0]));
  assign sm[0] = {8'h00, sum8};

  pipelined_adder_nbit #(.WIDTH(16), .STAGES(4)) u_dut16_4 (
    .clk_in(clk), .rst_n_in(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .a_in(a_s), .b_in(b_s), .c_in(c_s),
`ifdef ADDER_SUB_EN
    .sub_in(sub_s),
`endif
    .out_valid(ov[1]), .out_ready(out_ready), .sum(sm[1]), .c_out(co[1]), .ovf(of[1]));

  pipelined_adder_nbit #(.WIDTH(16), .STAGES(1)) u_dut16_1 (
    .clk_in(clk), .rst_n_in(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .a_in(a_s), .b_in(b_s), .c_in(c_s),
`ifdef ADDER_SUB_EN
    .sub_in(sub_s),
`endif
    .out_valid(ov[2]), .out_ready(out_ready), .sum(sm[2]), .c_out(co[2]), .ovf(of[2]));

  function automatic res_t ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic c, input logic sub);
    longint unsigned mask, av, bv, t;
    res_t r;
    mask  = (64'd1 << w) - 64'd1;
    av    = 64'(a) & mask;
    bv    = sub ? (~64'(b) & mask) : (64'(b) & mask);
    t     = av + bv + (sub ? 64'd1 : 64'(c));
    r.sum = 16'(t & mask);
    r.co  = ((t >> w) & 64'd1) != 0;
    r.ovf = (((av >> (w - 1)) & 64'd1) == ((bv >> (w - 1)) & 64'd1)) &&
            (((t >> (w - 1)) & 64'd1) != ((av >> (w - 1)) & 64'd1));
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) q[d].delete();
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && out_ready) begin
          checks++;
          if (q[d].size() == 0) begin
            failures++;
            $display("FAIL sb%0d_spurious: out_valid=1 sum=%h, required no result pending", d, sm[d]);
          end else begin
            mon_e   = q[d].pop_front();
            mon_got = '{sum: sm[d], co: co[d], ovf: of[d]};
            if (mon_got !== mon_e.r) begin
              failures++;
              $display("FAIL sb%0d_result: got sum=%h c_out=%b ovf=%b, required sum=%h c_out=%b ovf=%b",
                       d, mon_got.sum, mon_got.co, mon_got.ovf, mon_e.r.sum, mon_e.r.co, mon_e.r.ovf);
            end
            if (mon_e.chk && lat_chk) begin
              checks++;
              if (cyc - mon_e.cyc != LAT[d]) begin
                failures++;
                $display("FAIL sb%0d_latency: got %0d, required %0d", d, cyc - mon_e.cyc, LAT[d]);
              end
            end
          end
        end
        if (in_valid && rdy[d]) begin
          mon_e.r   = ref_op(WID[d], a_s, b_s, c_s, sub_eff);
          mon_e.cyc = cyc;
          mon_e.chk = lat_chk;
          q[d].push_back(mon_e);
        end
      end
    end
  end

  task automatic send_wait(input logic [7:0] a, input logic [7:0] b, input logic c,
                           input logic sub, output int n);
    @(posedge clk); #1;
    in_valid = 1'b1;
    a_s = {8'($urandom), a};
    b_s = {8'($urandom), b};
    c_s = c;
    sub_s = sub;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!ov[0] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ov[0], sum8, co[0], of[0], ov[1], ov[2]} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs: got ov=%b sum=%h co=%b ovf=%b, required all zero", ov[0], sum8, co[0], of[0]);
    end
    checks++;
    if (rdy[0] !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b, required 1", rdy[0]);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ov[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_valid: got %b, required 0", ov[0]);
    end
  endtask

  task automatic test_carry();
    int n;
    send_wait(8'hFF, 8'h01, 1'b0, 1'b0, n);
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL carry_latency: got %0d, required 2", n);
    end
    checks++;
    if ({sum8, co[0], of[0]} !== {8'h00, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL carry_result: got sum=%h co=%b ovf=%b, required sum=00 co=1 ovf=0", sum8, co[0], of[0]);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] ta [2] = '{8'h7F, 8'h80};
    logic [7:0] tb [2] = '{8'h01, 8'h80};
    logic [9:0] te [2] = '{{8'h80, 1'b0, 1'b1}, {8'h00, 1'b1, 1'b1}};
    int n;
    for (int i = 0; i < 2; i++) begin
      send_wait(ta[i], tb[i], 1'b0, 1'b0, n);
      checks++;
      if ({sum8, co[0], of[0]} !== te[i]) begin
        failures++;
        $display("FAIL overflow_%0d: got {sum,co,ovf}=%h, required %h", i, {sum8, co[0], of[0]}, te[i]);
      end
    end
  endtask

`ifdef ADDER_SUB_EN
  task automatic test_sub();
    logic [7:0] ta [2] = '{8'h05, 8'h80};
    logic [7:0] tb [2] = '{8'h07, 8'h01};
    logic [9:0] te [2] = '{{8'hFE, 1'b0, 1'b0}, {8'h7F, 1'b1, 1'b1}};
    int n;
    for (int i = 0; i < 2; i++) begin
      send_wait(ta[i], tb[i], 1'b0, 1'b1, n);
      checks++;
      if ({sum8, co[0], of[0]} !== te[i]) begin
        failures++;
        $display("FAIL sub_%0d: got {sum,co,ovf}=%h, required %h", i, {sum8, co[0], of[0]}, te[i]);
      end
    end
    sub_s = 1'b0;
  endtask
`endif

  task automatic test_back_to_back();
    logic [8:0] want;
    sub_s = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      if (t >= 2) begin
        want = 9'(3 * (t - 2) + ((t - 2) % 2));
        checks++;
        if (ov[0] !== 1'b1 || {co[0], sum8} !== want) begin
          failures++;
          $display("FAIL b2b_%0d: got valid=%b {co,sum}=%h, required valid=1 %h", t - 2, ov[0], {co[0], sum8}, want);
        end
      end
      checks++;
      if (rdy[0] !== 1'b1) begin
        failures++;
        $display("FAIL b2b_in_ready_%0d: got %b, required 1", t, rdy[0]);
      end
      in_valid = (t < 8);
      a_s = 16'(t);
      b_s = 16'(2 * t);
      c_s = 1'(t % 2);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    res_t ra, rb, got;
    lat_chk = 1'b0;
    ra = ref_op(8, 16'h003C, 16'h00D9, 1'b1, 1'b0);
    rb = ref_op(8, 16'h0081, 16'h00A5, 1'b0, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; a_s = 16'h003C; b_s = 16'h00D9; c_s = 1'b1; sub_s = 1'b0;
    @(posedge clk); #1;
    a_s = 16'h0081; b_s = 16'h00A5; c_s = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      got = '{sum: sm[0], co: co[0], ovf: of[0]};
      checks++;
      if (ov[0] !== 1'b1 || rdy[0] !== 1'b0 || got !== ra) begin
        failures++;
        $display("FAIL stall_hold_%0d: got valid=%b ready=%b res=%h, required valid=1 ready=0 res=%h", i, ov[0], rdy[0], got, ra);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    got = '{sum: sm[0], co: co[0], ovf: of[0]};
    checks++;
    if (ov[0] !== 1'b1 || got !== rb) begin
      failures++;
      $display("FAIL stall_release: got valid=%b res=%h, required valid=1 res=%h", ov[0], got, rb);
    end
    @(posedge clk); #1;
    checks++;
    if (ov[0] !== 1'b0) begin
      failures++;
      $display("FAIL stall_drained: got valid=%b, required 0", ov[0]);
    end
    repeat (8) @(posedge clk);
    #1;
    lat_chk = 1'b1;
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    in_valid = 1'b1; a_s = 16'h1234; b_s = 16'h4321; c_s = 1'b0;
    @(posedge clk); #1;
    a_s = 16'h0F0F; b_s = 16'h00F1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (ov[0] !== 1'b1) begin
      failures++;
      $display("FAIL midflight_pre: got valid=%b, required 1", ov[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov[0] !== 1'b0 || sum8 !== 8'h00 || ov[1] !== 1'b0) begin
      failures++;
      $display("FAIL midflight_async: got valid=%b sum=%h valid16=%b, required 0 00 0", ov[0], sum8, ov[1]);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ov[0] | ov[1] | ov[2]) begin
        failures++;
        $display("FAIL midflight_after_%0d: got valid=%b%b%b, required 000", i, ov[0], ov[1], ov[2]);
      end
    end
  endtask

  task automatic test_random(input int n, input bit rand_ready);
    lat_chk = !rand_ready;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) != 0);
      a_s       = 16'($urandom);
      b_s       = 16'($urandom);
      c_s       = 1'($urandom);
      sub_s     = 1'($urandom);
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    lat_chk = 1'b1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (q[d].size() != 0) begin
        failures++;
        $display("FAIL random_drain_%0d: got %0d results outstanding, required 0", d, q[d].size());
      end
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_s = '0; b_s = '0; c_s = 1'b0; sub_s = 1'b0;
    #1 rst_n = 1'b0;
    test_reset();
    test_carry();
    test_overflow();
`ifdef ADDER_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random(1200, 1'b0);
    test_random(600, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_nbit.md
Name: pipelined_adder_nbit

Overview:
Parametrised, pipelined ripple-carry adder that generalises the 1-bit full adder to WIDTH bits.
- Addition is split into STAGES register slices, each adding WIDTH/STAGES bits and passing its carry to the next slice.
- A valid/ready handshake with full-pipeline stall lets it feed the ALU result path at one operation per clock.
- Also produces a signed overflow flag.

Parameters:
WIDTH, 8, operand and sum width in bits; must be >= 1
STAGES, 2, pipeline depth (register slices); 1 <= STAGES <= WIDTH, WIDTH % STAGES == 0, otherwise elaboration error

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous reset, active low
in_valid  input  1  operands valid this cycle
in_ready  output  1  block accepts operands this cycle
a_in  input  WIDTH  operand A
b_in  input  WIDTH  operand B
c_in  input  1  carry in
sub_in  input  1  subtract select (only with ADDER_SUB_EN; otherwise port absent)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
c_out  output  1  carry out of bit WIDTH-1
ovf  output  1  signed two's-complement overflow

Behaviour:
- Clock and reset:
  - One clock, clk_in.
  - Reset is asynchronous and active-low on rst_n_in.
  - Reset clears every stage valid bit.
  - Outputs under reset: out_valid=0, sum=0, c_out=0, ovf=0.
  - Data registers also reset to 0.
- Handshake:
  - advance = !out_valid | out_ready; in_ready = advance, combinational.
  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
  - When advance=1, all stages shift one slot together. A stage with valid=0 shifts in as a bubble; bubbles are not compressed.
  - When advance=0, all stage registers and all outputs hold, bit-exact.
  - Simultaneous in-transfer and out-transfer in the same cycle is legal and sustains 1 result per clock.
- Datapath:
  - CHUNK = WIDTH/STAGES.
  - Stage k (0-based) adds operand bits [k*CHUNK +: CHUNK] plus the carry from stage k-1. Stage 0 uses c_in.
  - Upper, not-yet-added operand bits travel forward with the carry.
  - Completed lower sum bits are delayed so all bits align at the output.
- Latency: exactly STAGES cycles from in-transfer to out_valid when no stall occurs.
- Arithmetic:
  - {c_out, sum} = a_in + b_in + c_in, computed modulo 2^(WIDTH+1).
  - ovf = (a[MSB] == b'[MSB]) & (sum[MSB] != a[MSB]), where b' is the operand actually added.
- STAGES=1 degenerates to a single registered WIDTH-bit adder, latency 1.
- Input hygiene: when in_valid=0, a_in, b_in and c_in are don't-care and must not affect any output.
- Reset mid-operation: all in-flight results are discarded, out_valid drops asynchronously, and nothing reappears after reset release.

Optional Feature:
Macro: ADDER_SUB_EN
- Defined:
  - sub_in port exists and is captured with the operands.
  - sub_in=1 computes a_in + ~b_in + 1. c_in is ignored, and b' = ~b_in for the ovf rule.
  - c_out=1 means no borrow.
  - sub_in=0 behaves as a plain add.
- Undefined: no sub_in port; the block always adds.

Test Plan:
(WIDTH=8, STAGES=2 unless noted)
1. Carry and latency: a=0xFF, b=0x01, c_in=0, out_ready=1 → 2 cycles later out_valid=1, sum=0x00, c_out=1, ovf=0.
2. Signed overflow: a=0x7F, b=0x01, c_in=0 → sum=0x80, c_out=0, ovf=1. a=0x80, b=0x80 → sum=0x00, c_out=1, ovf=1.
3. Throughput and stall:
   - Stream 8 back-to-back pairs (i, 2i, c_in=i[0]) with out_ready=1 → 8 consecutive results i+2i+i[0] at 1/clock.
   - Then hold out_ready=0 for 3 cycles with a pending result → in_ready=0, outputs stable; nothing is lost or duplicated after release.
4. Reset mid-flight: two ops in the pipe, assert rst_n_in low between clock edges → out_valid=0 and sum=0 immediately; after release, out_valid stays 0 until a new input.
5. ADDER_SUB_EN: sub_in=1, a=0x05, b=0x07 → sum=0xFE, c_out=0, ovf=0. a=0x80, b=0x01 → sum=0x7F, c_out=1, ovf=1.
6. Parameter sweep: WIDTH=16, STAGES=4 and STAGES=1 → random 1000 ops match reference addition, with latency 4 and 1 respectively.
